modulo_escalonador_divisor: RTL
===============================

# modulo_escalonador_divisor

Round-robin time-slot scheduler built on the ripple frequency divider's output. Synchronises and edge-detects the divided clock into a one-cycle tick, then grants that time base to one of `N_REQ` requesters at a time. Each grant lasts up to `SLOT_TICKS` divided-clock periods or until the holder releases it. Sits between `modulo_divisor_frequencia` and the slow-rate consumers (display scan, blink, debounce) so they share one divider instead of instantiating their own.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `SLOT_TICKS`, default 8: maximum slot length in divided-clock ticks, ≥1.
- `clock`  in  1  system clock; all logic on its rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `clock_div`  in  1  divider output; ripple-derived, so treated as asynchronous to `clock`.
- `req`  in  N_REQ  level request per requester.
- `done`  in  N_REQ  early-release strobe; honoured only for the current holder.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `slot_tick`  out  1  one-cycle pulse per `clock_div` rising edge, registered.
- `busy`  out  1  high while in GRANT.

## Operation
- **Synchroniser:** `clock_div` passes through two flops (s1, s2), then a history flop s3. The registered `slot_tick` is s2 & ~s3.
- **Reset values:** `gnt`=0, `busy`=0, `slot_tick`=0, all sync flops 0, state IDLE, RR pointer 0, slot counter 0.
- **States:**
  - **IDLE:** if any `req`, go to GRANT. Grant the first requester at or after the pointer (ascending index, wrap at N_REQ-1→0). Clear the slot counter.
  - **GRANT:** hold `gnt[i]` and `busy`=1. Each `slot_tick` increments the counter, width clog2(SLOT_TICKS+1). A release event goes to GUARD:
    - `done[i]`=1, or
    - `req[i]`=0, or
    - timeout (see Configuration).
  - **GUARD:** `gnt`=0, `busy`=0 for exactly one cycle. Pointer ← (i+1) mod N_REQ. Then:
    - if any `req`, go directly to GRANT using the updated pointer;
    - otherwise go to IDLE.
- **Boundary and precedence rules:**
  - Simultaneous release causes (e.g. `done` + timeout) produce one release.
  - `done[j]` for j≠holder is ignored.
  - A single requester re-requesting is granted again after the GUARD cycle.
  - `gnt` is never multi-hot, and never changes without passing through GUARD.
- **Counter:** saturates at SLOT_TICKS, never wraps.
- **Clear mid-grant:** `clear` during GRANT drops `gnt` on the next edge; pointer returns to 0.

## Timing
- **`slot_tick` latency:** if `clock_div` is first sampled high at edge k, `slot_tick` is high during cycle k+3 only.
- **Request to grant:** `req` sampled at edge t in IDLE → `gnt` high from edge t+1.
- **Release:** release sampled at edge t → `gnt` low from t+1 (GUARD). The next `gnt` is high from t+2 if any `req` is high at t+1.
- **Timeout:** the release is sampled on the edge where the SLOT_TICKS-th `slot_tick` of the grant is high.
- **Tick/grant overlap:** ticks arriving in IDLE or GUARD are not counted toward any slot. A tick in the same cycle `gnt` first rises is counted.
- **Input rate:** `clock_div` period must be ≥6 `clock` periods.

## Configuration
- **`SCHED_SLOT_TIMEOUT_EN` defined:** the counter reaching SLOT_TICKS forces release (preemptive time-slicing).
- **Not defined:**
  - no timeout; a grant is held until `done` or `req` drop, and the counter only saturates;
  - `slot_tick` and all other behaviour are unchanged.

## Test plan
- **Reset:** hold `clear` 3 cycles with `req`=4'b1111 and `clock_div` toggling → `gnt`=0, `busy`=0, `slot_tick`=0 throughout; `gnt`=4'b0001 one cycle after `clear` falls.
- **Tick generation:** `clock_div` period 16 cycles, 8 high → exactly one `slot_tick` per period, 3 cycles after each rising edge; no pulse on falling edges.
- **Round robin with timeout (`SCHED_SLOT_TIMEOUT_EN`, SLOT_TICKS=8):** `req`=4'b1111 held → `gnt` sequence 0001,0010,0100,1000,0001. Each grant lasts until its 8th tick, with one GUARD cycle of `gnt`=0 between grants.
- **Early release:** holder 1 pulses `done[1]` after 2 ticks while `req`=4'b1010 → `gnt` 0010→0000→1000. A `done[3]` pulse during the holder-1 slot has no effect.
- **No timeout (macro off):** `req`=4'b0011, no `done`, 20 ticks → `gnt` stays 0001. Dropping `req[0]` → GUARD, then `gnt`=0010.
- **Mid-grant reset:** assert `clear` on tick 3 of a slot held by requester 2 → next edge `gnt`=0. After release with `req`=4'b0100, `gnt`=0100 and the counter restarts at 0.

Source files
------------

// File: rtl/modulo_escalonador_divisor.sv
// -----------------------------------------------------------------------------
// modulo_escalonador_divisor
//
// Round-robin time-slot scheduler driven by the ripple frequency divider.
// The divided clock is synchronised into the system clock domain and
// edge-detected into a one-cycle slot_tick. That time base is then granted
// to one requester at a time. A grant ends when the holder pulses done,
// drops its req, or (optionally) uses up SLOT_TICKS ticks. Every grant is
// followed by exactly one GUARD cycle with gnt all-zero.
//
// Optional feature macro: SCHED_SLOT_TIMEOUT_EN
//   defined   -> reaching SLOT_TICKS ticks forces release (time slicing)
//   undefined -> no timeout; the slot counter only saturates
//
// Parameters:
//   N_REQ       number of requesters (2..8)
//   SLOT_TICKS  maximum slot length in divided-clock ticks (>=1)
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   synchronous active-high reset
//   clock_div  in   divider output, asynchronous to clock
//   req        in   level request per requester
//   done       in   early-release strobe, honoured for the holder only
//   gnt        out  one-hot grant, registered
//   slot_tick  out  one-cycle pulse per clock_div rising edge, registered
//   busy       out  high while a grant is held
// -----------------------------------------------------------------------------
module modulo_escalonador_divisor #(
  parameter int N_REQ      = 4,
  parameter int SLOT_TICKS = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             clock_div,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             slot_tick,
  output logic             busy
);

  localparam int CNT_W = $clog2(SLOT_TICKS + 1);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_TICKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] holder, holder_n;
  logic [CNT_W-1:0] slot_cnt, slot_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] pick;
  logic             timeout_hit;

  logic sync_s1_p0, sync_s2_p1, sync_s3_p2;

  // First requester at or after p, ascending with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic             found;
    idx   = p;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    return sel;
  endfunction

  // Stage p0..p2: two-flop synchroniser plus history flop; tick on rising edge
  always_ff @(posedge clock) begin
    if (clear) begin
      sync_s1_p0 <= 1'b0;
      sync_s2_p1 <= 1'b0;
      sync_s3_p2 <= 1'b0;
      slot_tick  <= 1'b0;
    end else begin
      sync_s1_p0 <= clock_div;
      sync_s2_p1 <= sync_s1_p0;
      sync_s3_p2 <= sync_s2_p1;
      slot_tick  <= sync_s2_p1 & ~sync_s3_p2;
    end
  end

`ifdef SCHED_SLOT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_TICKS - 1);
  // Release on the very edge that samples the last tick of the slot.
  assign timeout_hit = slot_tick && (slot_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign pick = rr_pick(req, ptr);
  assign busy = (state == GRANT);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    holder_n   = holder;
    slot_cnt_n = slot_cnt;
    gnt_n      = gnt;
    case (state)
      IDLE, GUARD: begin
        // ptr was already advanced on the release edge, so GUARD re-arbitrates fairly
        gnt_n   = '0;
        state_n = IDLE;
        if (|req) begin
          state_n    = GRANT;
          holder_n   = pick;
          gnt_n      = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          slot_cnt_n = '0;
        end
      end
      GRANT: begin
        if (slot_tick && (slot_cnt != CNT_MAX)) slot_cnt_n = slot_cnt + 1'b1;
        // All release causes collapse into a single transition.
        if (done[holder] || !req[holder] || timeout_hit) begin
          state_n = GUARD;
          gnt_n   = '0;
          ptr_n   = (holder == IDX_LAST) ? '0 : holder + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      ptr      <= '0;
      holder   <= '0;
      slot_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      holder   <= holder_n;
      slot_cnt <= slot_cnt_n;
      gnt      <= gnt_n;
    end
  end

endmodule
